// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier sequencer that drives an external ALU with ADC steps.
// Optional build macro ALU_MUL_ZERO_SKIP_EN: skip ADD cycles when the multiplier bit is 0.
module alu_mul_seq #(
    parameter int p_data_width  = 16,
    parameter int p_flags_width = 5
) (
    input  logic                     i_w_clk,
    input  logic                     i_w_reset,
    input  logic                     i_w_start,
    input  logic [p_data_width-1:0]  i_w_op_a,
    input  logic [p_data_width-1:0]  i_w_op_b,
    output logic                     o_w_busy,
    output logic                     o_w_done,
    output logic [p_data_width-1:0]  o_w_prod_hi,
    output logic [p_data_width-1:0]  o_w_prod_lo,
    output logic [p_data_width-1:0]  o_w_alu_op1,
    output logic [p_data_width-1:0]  o_w_alu_op2,
    output logic [3:0]               o_w_alu_opcode,
    output logic                     o_w_alu_carry,
    output logic                     o_w_alu_oe,
    input  logic [p_data_width-1:0]  i_w_alu_out,
    input  logic [p_flags_width-1:0] i_w_alu_flags
);

    localparam int W  = p_data_width;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

`ifdef ALU_MUL_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADD   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [W-1:0]  acc, mq, mcand;
    logic          c;
    logic [CW-1:0] cnt;
    logic [W-1:0]  prod_hi, prod_lo;
    logic [W-1:0]  acc_sh, mq_sh;
    logic          unused_flags;

    // {c, acc, mq} shifts right as one 2W+1 bit register.
    assign acc_sh = {c, acc[W-1:1]};
    assign mq_sh  = {acc[0], mq[W-1:1]};

    assign unused_flags = &{1'b0, i_w_alu_flags};

    always_ff @(posedge i_w_clk or posedge i_w_reset) begin
        if (i_w_reset) begin
            state   <= S_IDLE;
            acc     <= '0;
            mq      <= '0;
            mcand   <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            prod_hi <= '0;
            prod_lo <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_w_start) begin
                        mcand <= i_w_op_a;
                        mq    <= i_w_op_b;
                        acc   <= '0;
                        c     <= 1'b0;
                        cnt   <= '0;
                        state <= (ZERO_SKIP && !i_w_op_b[0]) ? S_SHIFT : S_ADD;
                    end
                end
                S_ADD: begin
                    acc   <= i_w_alu_out;
                    c     <= i_w_alu_flags[0];
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    acc <= acc_sh;
                    mq  <= mq_sh;
                    c   <= 1'b0;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST_ITER) begin
                        prod_hi <= acc_sh;
                        prod_lo <= mq_sh;
                        state   <= S_DONE;
                    end else begin
                        state <= (ZERO_SKIP && !mq_sh[0]) ? S_SHIFT : S_ADD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_w_busy       = (state != S_IDLE);
    assign o_w_done       = (state == S_DONE);
    assign o_w_prod_hi    = prod_hi;
    assign o_w_prod_lo    = prod_lo;
    assign o_w_alu_op1    = acc;
    assign o_w_alu_op2    = mq[0] ? mcand : '0;
    assign o_w_alu_opcode = 4'd0;
    assign o_w_alu_carry  = 1'b0;
    assign o_w_alu_oe     = (state == S_ADD);

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: W=16 and W=6 instances, each with a behavioural ADC ALU.
module tb_alu_mul_seq;

    localparam int W  = 16;
    localparam int W6 = 6;

    typedef struct {
        logic [31:0] prod;
        int          cyc;
        int          busy;
        int          oe;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // W=16 instance
    logic          start;
    logic [W-1:0]  op_a, op_b, prod_hi, prod_lo, alu_op1, alu_op2, alu_out;
    logic          busy, done, alu_carry, alu_oe;
    logic [3:0]    alu_opcode;
    logic [4:0]    alu_flags;
    logic [W:0]    alu_sum;

    assign alu_sum   = {1'b0, alu_op1} + {1'b0, alu_op2} + {{W{1'b0}}, alu_carry};
    assign alu_out   = !alu_oe ? '0 : (alu_opcode == 4'd0 ? alu_sum[W-1:0] : ~alu_sum[W-1:0]);
    assign alu_flags = {4'b0, alu_oe & alu_sum[W]};

    alu_mul_seq #(.p_data_width(W), .p_flags_width(5)) dut (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_start(start),
        .i_w_op_a(op_a), .i_w_op_b(op_b),
        .o_w_busy(busy), .o_w_done(done),
        .o_w_prod_hi(prod_hi), .o_w_prod_lo(prod_lo),
        .o_w_alu_op1(alu_op1), .o_w_alu_op2(alu_op2),
        .o_w_alu_opcode(alu_opcode), .o_w_alu_carry(alu_carry), .o_w_alu_oe(alu_oe),
        .i_w_alu_out(alu_out), .i_w_alu_flags(alu_flags)
    );

    // W=6 instance
    logic           start6;
    logic [W6-1:0]  op_a6, op_b6, prod_hi6, prod_lo6, alu_op1_6, alu_op2_6, alu_out6;
    logic           busy6, done6, alu_carry6, alu_oe6;
    logic [3:0]     alu_opcode6;
    logic [4:0]     alu_flags6;
    logic [W6:0]    alu_sum6;

    assign alu_sum6   = {1'b0, alu_op1_6} + {1'b0, alu_op2_6} + {{W6{1'b0}}, alu_carry6};
    assign alu_out6   = !alu_oe6 ? '0 : (alu_opcode6 == 4'd0 ? alu_sum6[W6-1:0] : ~alu_sum6[W6-1:0]);
    assign alu_flags6 = {4'b0, alu_oe6 & alu_sum6[W6]};

    alu_mul_seq #(.p_data_width(W6), .p_flags_width(5)) dut6 (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_start(start6),
        .i_w_op_a(op_a6), .i_w_op_b(op_b6),
        .o_w_busy(busy6), .o_w_done(done6),
        .o_w_prod_hi(prod_hi6), .o_w_prod_lo(prod_lo6),
        .o_w_alu_op1(alu_op1_6), .o_w_alu_op2(alu_op2_6),
        .o_w_alu_opcode(alu_opcode6), .o_w_alu_carry(alu_carry6), .o_w_alu_oe(alu_oe6),
        .i_w_alu_out(alu_out6), .i_w_alu_flags(alu_flags6)
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q16[$];
    exp_t q6[$];
    int   next_ok16 = 0;
    int   next_ok6  = 0;
    int   busy_run = 0;
    int   oe_cnt   = 0;
    bit   carry_seen = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Cycles from the accepting edge to the done cycle (done is sampled with cyc == edge + lat).
    function automatic int lat(input int w, input logic [31:0] b);
`ifdef ALU_MUL_ZERO_SKIP_EN
        return w + $countones(b);
`else
        return 2 * w;
`endif
    endfunction

    function automatic int adds(input int w, input logic [31:0] b);
`ifdef ALU_MUL_ZERO_SKIP_EN
        return $countones(b);
`else
        return w;
`endif
    endfunction

    // Monitor, W=16
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_run = 0;
            oe_cnt   = 0;
        end else begin
            if (busy) busy_run++; else busy_run = 0;
            if (alu_oe) begin
                oe_cnt++;
                if (alu_flags[0]) carry_seen = 1'b1;
            end
            if (done) begin
                if (q16.size() == 0) begin
                    chk("unexpected_done16", 1, 0);
                end else begin
                    e = q16.pop_front();
                    chk("prod16", {prod_hi, prod_lo}, e.prod);
                    chk("done_cycle16", cyc, e.cyc);
                    chk("busy_len16", busy_run, e.busy);
                    chk("oe_count16", oe_cnt, e.oe);
                end
                oe_cnt = 0;
            end else if (q16.size() != 0 && cyc > q16[0].cyc) begin
                e = q16.pop_front();
                chk("done_timeout16", cyc, e.cyc);
            end
        end
    end

    // Monitor, W=6
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done6) begin
                if (q6.size() == 0) begin
                    chk("unexpected_done6", 1, 0);
                end else begin
                    e = q6.pop_front();
                    chk("prod6", {20'd0, prod_hi6, prod_lo6}, e.prod);
                    chk("done_cycle6", cyc, e.cyc);
                end
            end else if (q6.size() != 0 && cyc > q6[0].cyc) begin
                e = q6.pop_front();
                chk("done_timeout6", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; waits until the DUT is known idle, pulses start for one edge.
    task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] prod, input bit push);
        exp_t e;
        int   k;
        while (cyc + 1 < next_ok16) @(negedge clk);
        start = 1'b1; op_a = a; op_b = b;
        @(negedge clk);
        k = cyc;
        start = 1'b0;
        e.prod = prod; e.cyc = k + lat(W, b); e.busy = lat(W, b) + 1; e.oe = adds(W, b);
        if (push) q16.push_back(e);
        next_ok16 = k + lat(W, b) + 2;
    endtask

    task automatic issue6(input logic [5:0] a, input logic [5:0] b, input logic [31:0] prod);
        exp_t e;
        int   k;
        while (cyc + 1 < next_ok6) @(negedge clk);
        start6 = 1'b1; op_a6 = a; op_b6 = b;
        @(negedge clk);
        k = cyc;
        start6 = 1'b0;
        e.prod = prod; e.cyc = k + lat(W6, {26'd0, b}); e.busy = 0; e.oe = 0;
        q6.push_back(e);
        next_ok6 = k + lat(W6, {26'd0, b}) + 2;
    endtask

    task automatic wait_idle16();
        while (cyc + 1 < next_ok16) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   k;
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        start6 = 1'b0; op_a6 = '0; op_b6 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_prod", {prod_hi, prod_lo}, 0);
        chk("rst_oe", alu_oe, 0);
        chk("rst_op1", alu_op1, 0);
        chk("rst_prod6", {prod_hi6, prod_lo6}, 0);
        #2 rst = 1'b0;
        @(negedge clk);

        issue16(16'h0003, 16'h0005, 32'h0000_000F, 1'b1);
        carry_seen = 1'b0;
        issue16(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1);
        wait_idle16();
        chk("carry_seen", carry_seen, 1);
        issue16(16'h1234, 16'h0000, 32'h0000_0000, 1'b1);
        issue16(16'hFFFF, 16'h0001, 32'h0000_FFFF, 1'b1);
        issue16(16'h8000, 16'h8000, 32'h4000_0000, 1'b1);
        issue16(16'hABCD, 16'h1234, 32'h0C37_4FA4, 1'b1);

        // Start held high with changing operands while busy.
        wait_idle16();
        start = 1'b1; op_a = 16'h0007; op_b = 16'h0009;
        @(negedge clk);
        k = cyc;
        e.prod = 32'h0000_003F; e.cyc = k + lat(W, 16'h0009);
        e.busy = lat(W, 16'h0009) + 1; e.oe = adds(W, 16'h0009);
        q16.push_back(e);
        next_ok16 = k + lat(W, 16'h0009) + 2;
        while (cyc + 1 < next_ok16) begin
            op_a = 16'(cyc * 5 + 1);
            op_b = 16'(cyc * 3 + 2);
            @(negedge clk);
        end
        op_a = 16'h0101; op_b = 16'h0033;
        @(negedge clk);
        k = cyc;
        start = 1'b0;
        e.prod = 32'h0000_3333; e.cyc = k + lat(W, 16'h0033);
        e.busy = lat(W, 16'h0033) + 1; e.oe = adds(W, 16'h0033);
        q16.push_back(e);
        next_ok16 = k + lat(W, 16'h0033) + 2;
        wait_idle16();

        // Reset mid-operation: outputs clear at once and the operation never completes.
        issue16(16'h00AB, 16'h00CD, 32'h0, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_prod", {prod_hi, prod_lo}, 0);
        chk("async_rst_oe", alu_oe, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        next_ok16 = 0;
        next_ok6  = 0;
        issue16(16'h0002, 16'h0002, 32'h0000_0004, 1'b1);

        issue6(6'h3F, 6'h3F, 32'h0000_0F81);
        issue6(6'h15, 6'h2A, 32'h0000_0372);

        for (int i = 0; i < 200 && (q16.size() != 0 || q6.size() != 0); i++) @(negedge clk);
        chk("drain16", q16.size(), 0);
        chk("drain6", q6.size(), 0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
